// File: rtl/count_seq_gen.sv
// Framed 1,2..,3..,0 symbol transmitter used to drive a counting-sequence detector.
// start/busy/done sequence frames; en freezes the whole machine without losing position.
module count_seq_gen #(
  parameter int CW  = 4,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           en,
  input  logic [CW-1:0]  pad,
  input  logic [CW-1:0]  hold,
  output logic [1:0]     num,
  output logic           busy,
  output logic           done,
  output logic [FCW-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND1 = 3'd1,
    SEND2 = 3'd2,
    SEND3 = 3'd3,
    TERM  = 3'd4
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [CW-1:0]  pad_l, pad_l_next;
  logic [CW-1:0]  hold_l, hold_l_next;
  logic [1:0]     num_next;
  logic           busy_next;
  logic           done_next;
  logic [FCW-1:0] frame_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pad_l     <= '0;
      hold_l    <= '0;
      num       <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pad_l     <= pad_l_next;
      hold_l    <= hold_l_next;
      num       <= num_next;
      busy      <= busy_next;
      done      <= done_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  // The run counter is compared before it increments, so a length field of
  // all ones yields 2^CW symbols without the counter ever wrapping.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    pad_l_next     = pad_l;
    hold_l_next    = hold_l;
    frame_cnt_next = frame_cnt;
    case (state)
      IDLE: begin
        if (en && start) begin
          pad_l_next  = pad;
          hold_l_next = hold;
          cnt_next    = '0;
          state_next  = SEND1;
        end
      end
      SEND1: begin
        if (en) begin
          cnt_next   = '0;
          state_next = SEND2;
        end
      end
      SEND2: begin
        if (en) begin
          if (cnt == pad_l) begin
            cnt_next   = '0;
            state_next = SEND3;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      SEND3: begin
        if (en) begin
          if (cnt == hold_l) begin
            cnt_next   = '0;
            state_next = TERM;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      TERM: begin
        if (en) begin
          frame_cnt_next = frame_cnt + 1'b1;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        pad_l_next     = '0;
        hold_l_next    = '0;
        frame_cnt_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    num_next  = 2'd0;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      SEND1: begin
        num_next  = 2'd1;
        busy_next = 1'b1;
      end
      SEND2: begin
        num_next  = 2'd2;
        busy_next = 1'b1;
      end
      SEND3: begin
        num_next  = 2'd3;
        busy_next = 1'b1;
      end
      TERM: begin
        busy_next = 1'b1;
        done_next = 1'b1;
      end
      default: begin
        num_next  = 2'd0;
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_count_seq_gen.sv
// Scoreboard bench for count_seq_gen: frames push their expected busy-cycle symbols,
// a negedge monitor pops and compares whenever the DUT shows busy.
module tb_count_seq_gen;

  localparam int CW  = 4;
  localparam int FCW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           en = 1'b1;
  logic [CW-1:0]  pad = '0;
  logic [CW-1:0]  hold = '0;
  logic [1:0]     num;
  logic           busy;
  logic           done;
  logic [FCW-1:0] frame_cnt;

  always #5 clk = ~clk;

  count_seq_gen #(.CW(CW), .FCW(FCW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .pad       (pad),
    .hold      (hold),
    .num       (num),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [1:0]     num;
    logic           done;
    logic [FCW-1:0] fc;
    int             gap;
  } rec_t;

  rec_t           sb[$];
  rec_t           mon_rec;
  int             checks = 0;
  int             failures = 0;
  int             idle_run = 0;
  logic [FCW-1:0] exp_fc = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected busy cycles of one frame; record stall_idx is repeated stall_n extra
  // times, trunc>=0 keeps only the first trunc records (frame cut by reset).
  task automatic push_frame(input int p, input int h, input int stall_idx,
                            input int stall_n, input int gap, input int trunc);
    rec_t r;
    int   pushed = 0;
    int   reps;
    for (int i = 0; i < p + h + 4; i++) begin
      if (i == 0)              r.num = 2'd1;
      else if (i <= p + 1)     r.num = 2'd2;
      else if (i <= p + h + 2) r.num = 2'd3;
      else                     r.num = 2'd0;
      r.done = (i == p + h + 3);
      r.fc   = exp_fc;
      reps   = (i == stall_idx) ? stall_n + 1 : 1;
      for (int k = 0; k < reps; k++) begin
        r.gap = (i == 0 && k == 0) ? gap : 0;
        if (trunc < 0 || pushed < trunc) begin
          sb.push_back(r);
          pushed++;
        end
      end
    end
    if (trunc < 0) exp_fc = exp_fc + 1'b1;
  endtask

  always @(negedge clk) begin
    if (busy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_output: busy with num=%0d done=%0d, expected no busy cycle at %0t",
                 num, done, $time);
      end else begin
        mon_rec = sb.pop_front();
        check("num", num, mon_rec.num);
        check("done", done, mon_rec.done);
        check("frame_cnt", frame_cnt, mon_rec.fc);
        if (mon_rec.gap >= 0) check("idle_gap", idle_run, mon_rec.gap);
        if (mon_rec.done) $display("frame end: frame_cnt=%0d t=%0t", frame_cnt, $time);
      end
      idle_run = 0;
    end else begin
      check("idle_num_done", {num, done}, 0);
      idle_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int p, input int h);
    pad   = CW'(p);
    hold  = CW'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(busy == 1'b0 && sb.size() == 0) && n < budget);
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy=%0d pending=%0d after %0d cycles, expected idle",
               name, busy, sb.size(), budget);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_num", num, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fc", frame_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // minimum frame, first-symbol latency
    push_frame(0, 0, -1, 0, -1, -1);
    start_frame(0, 0);
    check("t1_latency_num", num, 1);
    check("t1_latency_busy", busy, 1);
    wait_idle("t1", 20);
    check("t1_fc", frame_cnt, exp_fc);

    // pad=2 hold=1
    push_frame(2, 1, -1, 0, -1, -1);
    start_frame(2, 1);
    wait_idle("t2", 30);

    // en stall on second 2-symbol, pad changed mid-frame
    push_frame(1, 0, 2, 2, -1, -1);
    start_frame(1, 0);
    pad = 4'd9;
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    wait_idle("t3", 30);
    check("t3_fc", frame_cnt, exp_fc);

    // en stall during TERM stretches done, counts once
    push_frame(0, 0, 3, 2, -1, -1);
    start_frame(0, 0);
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    wait_idle("t3b", 30);
    check("t3b_fc", frame_cnt, exp_fc);

    // start held high: three frames, exactly one idle cycle between them
    push_frame(0, 0, -1, 0, -1, -1);
    push_frame(0, 0, -1, 0, 1, -1);
    push_frame(0, 0, -1, 0, 1, -1);
    pad   = '0;
    hold  = '0;
    start = 1'b1;
    tick();
    repeat (13) tick();
    start = 1'b0;
    wait_idle("t4", 30);
    check("t4_fc", frame_cnt, exp_fc);

    // reset in the middle of SEND3
    push_frame(0, 3, -1, 0, -1, 3);
    start_frame(0, 3);
    tick();
    tick();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_num", num, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_fc", frame_cnt, 0);
    check("t5_sb_empty", sb.size(), 0);
    tick();
    tick();
    reset  = 1'b0;
    exp_fc = '0;
    tick();
    push_frame(2, 2, -1, 0, -1, -1);
    start_frame(2, 2);
    check("t5_restart_num", num, 1);
    wait_idle("t5", 30);
    check("t5_restart_fc", frame_cnt, exp_fc);

    // maximum-length frames, frame counter wraps
    for (int f = 0; f < 256; f++) begin
      push_frame(15, 15, -1, 0, -1, -1);
      start_frame(15, 15);
      wait_idle("t6", 60);
    end
    check("t6_fc_wrap", frame_cnt, exp_fc);

    tick();
    check("end_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
